// File: rtl/pyramid_reader.sv
// Coarse-to-fine read-back of the three pyramid level buffers (L2, L1, L0), streamed over valid/ready.
// Optional PYR_LVL_MASK_EN adds lvl_mask[2:0] to skip individual levels.
module pyramid_reader #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef PYR_LVL_MASK_EN
  input  logic [2:0]        lvl_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic [1:0]        mem_lvl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [1:0]        pix_lvl,
  output logic              pix_eol,
  output logic              pix_eof
);

  // state | meaning
  // IDLE  | waiting for start
  // RD_L2 | issuing reads of level 2 (IMG_W/4 x IMG_H/4)
  // RD_L1 | issuing reads of level 1 (IMG_W/2 x IMG_H/2)
  // RD_L0 | issuing reads of level 0 (IMG_W x IMG_H)
  // DRAIN | all reads issued, waiting for in-flight read and FIFO to empty
  typedef enum logic [2:0] {IDLE, RD_L2, RD_L1, RD_L0, DRAIN} state_t;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int EW = PIX_W + 4;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, col_max;
  logic [RW-1:0]   row_q, row_d, row_max;
  logic            inflight_q, inflight_d;
  logic [3:0]      inf_mark_q, inf_mark_d;
  logic [EW-1:0]   out_q, out_d, skid_q, skid_d, new_ent;
  logic [1:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [2:0]      skip_q, skip_d, skip_in;
  logic [1:0]      cur_lvl;
  logic [2:0]      occ;
  logic            is_rd, pop, push, col_last, lvl_last;

`ifdef PYR_LVL_MASK_EN
  assign skip_in = lvl_mask;
`else
  assign skip_in = 3'b000;
`endif

  function automatic state_t lvl_state(input int l);
    case (l)
      2:       lvl_state = RD_L2;
      1:       lvl_state = RD_L1;
      default: lvl_state = RD_L0;
    endcase
  endfunction

  // Highest non-skipped level strictly below 'below'; DRAIN when none remain.
  function automatic state_t first_lvl(input logic [2:0] skip, input int below);
    first_lvl = DRAIN;
    for (int l = 0; l < 3; l++) begin
      if (l < below && !skip[l]) first_lvl = lvl_state(l);
    end
  endfunction

  always_comb begin
    case (state_q)
      RD_L1:   cur_lvl = 2'd1;
      RD_L0:   cur_lvl = 2'd0;
      default: cur_lvl = 2'd2;
    endcase
  end

  assign is_rd    = (state_q == RD_L2) || (state_q == RD_L1) || (state_q == RD_L0);
  assign col_max  = CW'((IMG_W >> cur_lvl) - 1);
  assign row_max  = RW'((IMG_H >> cur_lvl) - 1);
  assign col_last = (col_q == col_max);
  assign lvl_last = col_last && (row_q == row_max);

  always_comb begin
    case (cur_lvl)
      2'd0:    mem_addr = (ADDR_W'(row_q) << CW) + ADDR_W'(col_q);
      2'd1:    mem_addr = (ADDR_W'(row_q) << (CW - 1)) + ADDR_W'(col_q);
      default: mem_addr = (ADDR_W'(row_q) << (CW - 2)) + ADDR_W'(col_q);
    endcase
  end

  // A pop in the same cycle frees its slot, which keeps 1 pixel/cycle with ready high.
  assign pop     = (cnt_q != 2'd0) && pix_ready;
  assign push    = inflight_q;
  assign occ     = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign mem_rd  = is_rd && ((occ < 3'd2) || (pop && (occ == 3'd2)));
  assign mem_lvl = cur_lvl;
  assign new_ent = {inf_mark_q, mem_rdata};

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    cnt_d      = cnt_q;
    inflight_d = mem_rd;
    inf_mark_d = {cur_lvl, col_last, lvl_last};
    case (cnt_q)
      2'd0: begin
        if (push) begin
          out_d = new_ent;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          out_d = new_ent;
        end else if (pop) begin
          cnt_d = 2'd0;
        end else if (push) begin
          skid_d = new_ent;
          cnt_d  = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          out_d = skid_q;
          if (push) skid_d = new_ent;
          else      cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    skip_d  = skip_q;
    case (state_q)
      IDLE: begin
        // A start landing on the done cycle belongs to the finished frame and is dropped.
        if (start && !done_q) begin
          skip_d = skip_in;
          if (first_lvl(skip_in, 3) == DRAIN) done_d  = 1'b1;
          else                                state_d = first_lvl(skip_in, 3);
        end
      end
      RD_L2, RD_L1, RD_L0: begin
        if (mem_rd) begin
          if (col_last) begin
            col_d = '0;
            row_d = lvl_last ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (lvl_last) state_d = first_lvl(skip_q, int'(cur_lvl));
        end
      end
      DRAIN: begin
        if (cnt_d == 2'd0 && !inflight_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      inf_mark_q <= '0;
      out_q      <= '0;
      skid_q     <= '0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
      skip_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inflight_q <= inflight_d;
      inf_mark_q <= inf_mark_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      skip_q     <= skip_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pix_valid = (cnt_q != 2'd0);
  assign pix_out   = out_q[PIX_W-1:0];
  assign pix_eof   = out_q[PIX_W];
  assign pix_eol   = out_q[PIX_W+1];
  assign pix_lvl   = out_q[PIX_W+3:PIX_W+2];

endmodule
